multicycle_ctrl: RTL

Multi-cycle sequencer for the RV32I subset core (R-type, I-type ALU, lw, sw, beq, jal, jalr). It replaces single-cycle decode when the core shares one memory port for instruction fetch and data. A Moore FSM steps the shared ALU, register file, IR/PC registers and memory port through fetch, decode, execute, memory and writeback. Memory accesses use a ready handshake. The block also counts retired instructions.

---
 rtl/multicycle_ctrl.sv | 218 +++++++++++++++++++++
 1 files changed

// File: rtl/multicycle_ctrl.sv
// Multi-cycle sequencer for a small RV32I core that shares one memory port
// between instruction fetch and data access. A Moore FSM walks the datapath
// through fetch, decode, execute, memory and writeback. The block also keeps
// a count of retired instructions and a sticky illegal-opcode flag.
//
// Memory handshake: while mem_read or mem_write is high, the request and the
// address select (adr_src) stay stable. The access completes in the first
// cycle that mem_ready is high. mem_ready in a state with no request is ignored.
module multicycle_ctrl #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [6:0]       op,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             pc_write,
    output logic             ir_write,
    output logic             adr_src,
    output logic             mem_read,
    output logic             mem_write,
    output logic             reg_write,
    output logic [1:0]       alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [1:0]       result_src,
    output logic [1:0]       alu_op,
    output logic [1:0]       imm_src,
    output logic             illegal,
    output logic [3:0]       state,
    output logic [CNT_W-1:0] instret
);

    localparam logic [6:0] OP_R    = 7'd51;
    localparam logic [6:0] OP_I    = 7'd19;
    localparam logic [6:0] OP_LW   = 7'd3;
    localparam logic [6:0] OP_SW   = 7'd35;
    localparam logic [6:0] OP_BEQ  = 7'd99;
    localparam logic [6:0] OP_JAL  = 7'd111;
    localparam logic [6:0] OP_JALR = 7'd103;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_EXECI    = 4'd7,
        S_ALUWB    = 4'd8,
        S_BEQ      = 4'd9,
        S_JALR     = 4'd10,
        S_JUMP     = 4'd11,
        S_ILLEGAL  = 4'd15
    } state_t;

    state_t           r_state;
    state_t           w_next_state;
    logic             r_illegal;
    logic [CNT_W-1:0] r_instret;
    logic             w_retire;

    logic             w_pc_write;
    logic             w_ir_write;
    logic             w_mem_read;
    logic             w_mem_write;
    logic             w_reg_write;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_FETCH;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic: memory states hold until mem_ready
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_FETCH:    w_next_state = mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (op)
                    OP_LW, OP_SW: w_next_state = S_MEMADR;
                    OP_R:         w_next_state = S_EXECR;
                    OP_I:         w_next_state = S_EXECI;
                    OP_BEQ:       w_next_state = S_BEQ;
                    OP_JAL:       w_next_state = S_JUMP;
                    OP_JALR:      w_next_state = S_JALR;
                    default:      w_next_state = S_ILLEGAL;
                endcase
            end
            S_MEMADR:   w_next_state = (op == OP_SW) ? S_MEMWRITE : S_MEMREAD;
            S_MEMREAD:  w_next_state = mem_ready ? S_MEMWB : S_MEMREAD;
            S_MEMWB:    w_next_state = S_FETCH;
            S_MEMWRITE: w_next_state = mem_ready ? S_FETCH : S_MEMWRITE;
            S_EXECR:    w_next_state = S_ALUWB;
            S_EXECI:    w_next_state = S_ALUWB;
            S_ALUWB:    w_next_state = S_FETCH;
            S_BEQ:      w_next_state = S_FETCH;
            S_JALR:     w_next_state = S_JUMP;
            S_JUMP:     w_next_state = S_ALUWB;
            S_ILLEGAL:  w_next_state = S_ILLEGAL;
            // Unused encodings are treated as a fault and parked
            default:    w_next_state = S_ILLEGAL;
        endcase
    end

    // Output decode: every output defaults to 0 and is set only where used
    always_comb begin
        w_pc_write  = 1'b0;
        w_ir_write  = 1'b0;
        adr_src     = 1'b0;
        w_mem_read  = 1'b0;
        w_mem_write = 1'b0;
        w_reg_write = 1'b0;
        alu_src_a   = 2'b00;
        alu_src_b   = 2'b00;
        result_src  = 2'b00;
        alu_op      = 2'b00;
        imm_src     = 2'b00;
        case (r_state)
            S_FETCH: begin
                w_mem_read = 1'b1;
                alu_src_b  = 2'b10;
                result_src = 2'b10;
                w_ir_write = mem_ready;
                w_pc_write = mem_ready;
            end
            S_DECODE: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b01;
                imm_src   = (op == OP_JAL) ? 2'b11 : 2'b10;
            end
            S_MEMADR: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
                imm_src   = (op == OP_SW) ? 2'b01 : 2'b00;
            end
            S_MEMREAD: begin
                adr_src    = 1'b1;
                w_mem_read = 1'b1;
            end
            S_MEMWB: begin
                result_src  = 2'b01;
                w_reg_write = 1'b1;
            end
            S_MEMWRITE: begin
                adr_src     = 1'b1;
                w_mem_write = 1'b1;
            end
            S_EXECR: begin
                alu_src_a = 2'b10;
                alu_op    = 2'b10;
            end
            S_EXECI: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
                alu_op    = 2'b11;
            end
            S_ALUWB: begin
                w_reg_write = 1'b1;
            end
            S_BEQ: begin
                alu_src_a  = 2'b10;
                alu_op     = 2'b01;
                imm_src    = 2'b10;
                w_pc_write = zero;
            end
            S_JALR: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
            end
            S_JUMP: begin
                w_pc_write = 1'b1;
                alu_src_a  = 2'b01;
                alu_src_b  = 2'b10;
            end
            default: ;
        endcase
    end

    // Strobes are gated by reset so nothing is written while rst_n is low
    assign pc_write  = w_pc_write  & rst_n;
    assign ir_write  = w_ir_write  & rst_n;
    assign mem_read  = w_mem_read  & rst_n;
    assign mem_write = w_mem_write & rst_n;
    assign reg_write = w_reg_write & rst_n;

    // An instruction retires when a completing state hands back to FETCH
    assign w_retire = (w_next_state == S_FETCH) &&
                      ((r_state == S_MEMWB) || (r_state == S_MEMWRITE) ||
                       (r_state == S_ALUWB) || (r_state == S_BEQ));

    // Retired-instruction counter, wraps naturally
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_instret <= '0;
        end else if (w_retire) begin
            r_instret <= r_instret + CNT_W'(1);
        end
    end

    // Sticky illegal flag, set on entry to ILLEGAL and held until reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_illegal <= 1'b0;
        end else if (w_next_state == S_ILLEGAL) begin
            r_illegal <= 1'b1;
        end
    end

    assign illegal = r_illegal;
    assign state   = r_state;
    assign instret = r_instret;

endmodule
